// File: rtl/trade_scheduler.sv
// trade_scheduler: divides clk into decision ticks, samples the bid/ask feed,
// decides on at most one BUY/SELL per tick and issues it over valid/ack.
//
// Handshake: trade_valid is raised by the scheduler and stays high, with
// trade_side/trade_price frozen, until the first clk edge where trade_ack=1;
// that edge is the transfer. trade_ack while trade_valid=0 has no effect.
module trade_scheduler #(
  parameter int TICK_DIV       = 2097152,
  parameter int MAX_POS        = 8,
  parameter int WIDE_SPREAD    = 20,
  parameter int COOLDOWN_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  buy_price,
  input  logic [7:0]  sell_price,
  input  logic        trade_ack,
  output logic        trade_valid,
  output logic        trade_side,
  output logic [7:0]  trade_price,
  output logic [7:0]  position,
  output logic [15:0] trade_count,
  output logic [2:0]  state
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SAMPLE = 3'd2,
    DECIDE = 3'd3,
    ISSUE  = 3'd4,
    COOL   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [CW-1:0]   cool_cnt;
  logic [7:0]      bid_q, ask_q;
  logic            buy_ok, sell_ok, accept;

  assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
  assign state  = state_q;
  // Buy into a crossed/locked book; unwind only on a wide spread (9-bit, no wrap).
  assign buy_ok  = (ask_q <= bid_q) && (position < 8'(MAX_POS));
  assign sell_ok = ({1'b0, ask_q} >= ({1'b0, bid_q} + 9'(WIDE_SPREAD))) &&
                   (position != 8'd0);
  assign accept  = (state_q == ISSUE) && trade_ack;

  // Free-running decision tick divider.
  always_ff @(posedge clk) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = WAIT;
      WAIT: begin
        if (!enable) state_d = IDLE;
        else if (tick) state_d = SAMPLE;
      end
      SAMPLE:  state_d = DECIDE;
      DECIDE:  state_d = (buy_ok || sell_ok) ? ISSUE : WAIT;
      ISSUE: begin
        if (trade_ack) state_d = (COOLDOWN_TICKS == 0) ? WAIT : COOL;
      end
      COOL: begin
        if (cool_cnt == '0) state_d = enable ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Price latch, trade offer, position/count bookkeeping and cooldown.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bid_q       <= 8'd0;
      ask_q       <= 8'd0;
      trade_valid <= 1'b0;
      trade_side  <= 1'b0;
      trade_price <= 8'd0;
      position    <= 8'd0;
      trade_count <= 16'd0;
      cool_cnt    <= '0;
    end else begin
      if (state_q == SAMPLE) begin
        bid_q <= buy_price;
        ask_q <= sell_price;
      end
      if (state_q == DECIDE) begin
        if (buy_ok) begin
          trade_valid <= 1'b1;
          trade_side  <= 1'b1;
          trade_price <= ask_q;
        end else if (sell_ok) begin
          trade_valid <= 1'b1;
          trade_side  <= 1'b0;
          trade_price <= bid_q;
        end
      end
      if (accept) begin
        trade_valid <= 1'b0;
        position    <= trade_side ? position + 8'd1 : position - 8'd1;
        if (trade_count != 16'hFFFF) trade_count <= trade_count + 16'd1;
        cool_cnt    <= CW'(COOLDOWN_TICKS);
      end
      if ((state_q == COOL) && tick && (cool_cnt != '0))
        cool_cnt <= cool_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_trade_scheduler.sv
// tb_trade_scheduler: directed bench for trade_scheduler with
// TICK_DIV=4, MAX_POS=2, COOLDOWN_TICKS=1. Inputs change and outputs are
// observed on the falling clk edge.
module tb_trade_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  buy_price, sell_price;
  logic        trade_ack;
  logic        trade_valid, trade_side;
  logic [7:0]  trade_price, position;
  logic [15:0] trade_count;
  logic [2:0]  state;

  int tests  = 0;
  int failed = 0;
  logic found;

  trade_scheduler #(
    .TICK_DIV(4), .MAX_POS(2), .WIDE_SPREAD(20), .COOLDOWN_TICKS(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .buy_price(buy_price), .sell_price(sell_price), .trade_ack(trade_ack),
    .trade_valid(trade_valid), .trade_side(trade_side),
    .trade_price(trade_price), .position(position),
    .trade_count(trade_count), .state(state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step until trade_valid is seen or the budget runs out.
  task automatic wait_valid(input int budget, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (trade_valid === 1'b1) hit = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; trade_ack = 1'b1;
    buy_price = 8'd60; sell_price = 8'd58;

    // 1: reset state, then release; tick lands on the 3rd cycle after release.
    step(2);
    check("rst_valid", trade_valid, 0);
    check("rst_side",  trade_side,  0);
    check("rst_price", trade_price, 0);
    check("rst_pos",   position,    0);
    check("rst_count", trade_count, 0);
    check("rst_state", state,       0);
    reset = 1'b1;
    step(1); check("wait_state", state, 1);
    step(2); check("wait_before_tick", state, 1);
    step(1); check("sample_after_tick", state, 2);

    // 2: crossed book with ack tied high -> BUY at ask, accepted next edge.
    step(1); check("decide_state", state, 3);
    check("no_valid_in_decide", trade_valid, 0);
    step(1);
    check("t2_valid", trade_valid, 1);
    check("t2_side",  trade_side,  1);
    check("t2_price", trade_price, 58);
    check("t2_state", state, 4);
    step(1);
    check("t2_valid_drop", trade_valid, 0);
    check("t2_pos",   position,    1);
    check("t2_count", trade_count, 1);
    check("t2_cool",  state,       5);

    // 3: ack withheld for 5 valid cycles; offer held stable, one increment.
    trade_ack = 1'b0;
    wait_valid(40, found);
    check("t3_found", found, 1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step(1);
      check("t3_hold_valid", trade_valid, 1);
      check("t3_hold_side",  trade_side,  1);
      check("t3_hold_price", trade_price, 58);
      check("t3_hold_pos",   position,    1);
    end
    trade_ack = 1'b1;
    step(1);
    check("t3_valid_drop", trade_valid, 0);
    check("t3_pos",   position,    2);
    check("t3_count", trade_count, 2);

    // 4: position at MAX_POS -> no further BUY; stray ack is ignored.
    wait_valid(40, found);
    check("t4_no_trade", found, 0);
    check("t4_pos",   position,    2);
    check("t4_count", trade_count, 2);

    // 5: spread of exactly 20 -> SELL at bid; spread 19 -> nothing.
    buy_price = 8'd50; sell_price = 8'd70;
    wait_valid(40, found);
    check("t5_found", found, 1);
    check("t5_side",  trade_side,  0);
    check("t5_price", trade_price, 50);
    step(1);
    sell_price = 8'd69;
    check("t5_valid_drop", trade_valid, 0);
    check("t5_pos",   position,    1);
    check("t5_count", trade_count, 3);
    wait_valid(40, found);
    check("t5_narrow_no_trade", found, 0);
    check("t5_narrow_pos", position, 1);

    // 6: reset in the middle of a handshake clears everything on that edge.
    buy_price = 8'd60; sell_price = 8'd58; trade_ack = 1'b0;
    wait_valid(40, found);
    check("t6_found", found, 1);
    check("t6_state_issue", state, 4);
    reset = 1'b0;
    step(1);
    check("t6_valid", trade_valid, 0);
    check("t6_pos",   position,    0);
    check("t6_count", trade_count, 0);
    check("t6_state", state,       0);
    check("t6_price", trade_price, 0);
    reset = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
